// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues word-aligned imem reads, tracks in-flight
// requests, discards responses belonging to a flushed fetch stream, and
// buffers returned instructions in a small circular queue for the decoder.
module fetch_queue #(
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'haaaaa000
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic [31:0]                imem_addr,
   output logic [3:0]                 imem_rmask,
   input  logic [31:0]                imem_rdata,
   input  logic                       imem_resp,
   input  logic                       redirect,
   input  logic [31:0]                redirect_pc,
   output logic                       deq_valid,
   input  logic                       deq_ready,
   output logic [31:0]                deq_inst,
   output logic [31:0]                deq_pc,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int OW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Outstanding/stale counters hold 0..4.
   localparam int CW = 3;
   // Occupancy + outstanding fits comfortably in 6 bits for DEPTH <= 16.
   localparam int BW = 6;
   localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);
   localparam logic [BW-1:0] DEPTH_C   = BW'(DEPTH);

   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_resp_pc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_stale;
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [OW-1:0] r_occ;
   logic [31:0]   r_inst [DEPTH];
   logic [31:0]   r_pc   [DEPTH];

   logic          w_issue;
   logic          w_resp_ok;
   logic          w_enq;
   logic          w_deq;
   logic [BW-1:0] w_committed;
   logic [31:0]   w_redirect_pc;

   // Slots already spoken for: queued entries plus live (non-stale) requests.
   // Stale requests never land in the queue, so they do not reserve space.
   assign w_committed   = BW'(r_occ) + BW'(r_outstanding) - BW'(r_stale);
   assign w_redirect_pc = redirect_pc & 32'hffff_fffc;

   assign w_issue   = !rst && !redirect && (r_outstanding < MAX_OUT_C)
                      && (w_committed < DEPTH_C);
   // A response with nothing in flight is a protocol error and is ignored.
   assign w_resp_ok = imem_resp && (r_outstanding != '0);
   assign w_enq     = !rst && !redirect && w_resp_ok && (r_stale == '0);
   assign w_deq     = !rst && !redirect && deq_valid && deq_ready;

   assign imem_addr  = r_fetch_pc;
   assign imem_rmask = w_issue ? 4'b1111 : 4'b0000;
   assign deq_valid  = (r_occ != '0);
   assign deq_inst   = r_inst[r_head];
   assign deq_pc     = r_pc[r_head];
   assign occupancy  = r_occ;

   // Fetch and response address tracking; a redirect restarts both streams.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_resp_pc  <= RESET_PC;
      end else if (redirect) begin
         r_fetch_pc <= w_redirect_pc;
         r_resp_pc  <= w_redirect_pc;
      end else begin
         if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
         if (w_enq)   r_resp_pc  <= r_resp_pc + 32'd4;
      end
   end

   // In-flight request bookkeeping; on redirect everything still in flight
   // becomes stale, minus a response that arrives in the redirect cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_outstanding <= '0;
         r_stale       <= '0;
      end else if (redirect) begin
         r_outstanding <= r_outstanding - CW'(w_resp_ok);
         r_stale       <= r_outstanding - CW'(w_resp_ok);
      end else begin
         r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_resp_ok);
         if (w_resp_ok && (r_stale != '0)) r_stale <= r_stale - CW'(1);
      end
   end

   // Queue pointers and occupancy; full/empty come from occupancy alone.
   always_ff @(posedge clk) begin
      if (rst || redirect) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
      end else begin
         if (w_enq) r_tail <= r_tail + PW'(1);
         if (w_deq) r_head <= r_head + PW'(1);
         case ({w_enq, w_deq})
            2'b10:   r_occ <= r_occ + OW'(1);
            2'b01:   r_occ <= r_occ - OW'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Queue storage; contents are only meaningful below occupancy, so no reset.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_inst[r_tail] <= imem_rdata;
         r_pc[r_tail]   <= r_resp_pc;
      end
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 DEPTH, 4, instruction queue entries; power of two, 2..16.
REQ-002 MAX_OUTSTANDING, 2, maximum in-flight imem requests; 1..4.
REQ-003 RESET_PC, 32'haaaaa000, first fetch address after reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 imem_addr  output  32  request address, word aligned.
REQ-007 imem_rmask  output  4  4'b1111 in an issue cycle, else 4'b0000.
REQ-008 imem_rdata  input  32  response instruction word.
REQ-009 imem_resp  input  1  one response per cycle when high; responses return in request order, latency >= 1 cycle.
REQ-010 redirect  input  1  flush and restart fetch (branch/jump taken).
REQ-011 redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 0.
REQ-012 deq_valid  output  1  head entry valid.
REQ-013 deq_ready  input  1  consumer accepts head this cycle.
REQ-014 deq_inst  output  32  head instruction word.
REQ-015 deq_pc  output  32  head instruction address.
REQ-016 occupancy  output  $clog2(DEPTH+1)  valid entries in queue.

Function
REQ-017 Internal state: fetch_pc, resp_pc, outstanding (in flight, incl. stale), stale (in flight to be dropped), circular queue with head/tail pointers.
REQ-018 Issue condition: !redirect && outstanding < MAX_OUTSTANDING && (occupancy + outstanding - stale) < DEPTH; guarantees no overflow.
REQ-019 Issue cycle: imem_addr = fetch_pc, imem_rmask = 4'b1111; fetch_pc += 4 at edge; outstanding += 1.
REQ-020 Non-issue cycle: imem_rmask = 0; imem_addr = fetch_pc.
REQ-021 Response with stale == 0 and no redirect: write {imem_rdata, resp_pc} at tail; resp_pc += 4; outstanding -= 1.
REQ-022 Response with stale > 0: data dropped; stale -= 1; outstanding -= 1; resp_pc unchanged.
REQ-023 No bypass: response in cycle N is visible at deq_* no earlier than cycle N+1.
REQ-024 deq_valid = (occupancy != 0); deq_inst/deq_pc come from head entry, combinational from registers.
REQ-025 Dequeue when deq_valid && deq_ready && !redirect; head advances by 1.
REQ-026 Simultaneous enqueue and dequeue: occupancy unchanged; legal at full and at 1.
REQ-027 deq_ready with deq_valid low has no effect.
REQ-028 Redirect cycle: no issue; queue emptied (occupancy 0 at next edge); fetch_pc and resp_pc load {redirect_pc[31:2],2'b00}; any deq handshake ignored.
REQ-029 Redirect cycle: stale <= outstanding minus 1 if imem_resp is high that cycle (that response is dropped); outstanding decrements likewise.
REQ-030 Back-to-back redirects: each recomputes stale per REQ-029; last redirect_pc wins.
REQ-031 fetch_pc/resp_pc arithmetic is modulo 2^32; 32'hfffffffc + 4 wraps to 0.
REQ-032 Pointers wrap modulo DEPTH; full/empty distinguished by occupancy, not pointer equality.
REQ-033 imem_resp with outstanding == 0 is a protocol error; ignored, no state change.

Reset
REQ-034 While rst high at an edge: fetch_pc = resp_pc = RESET_PC; outstanding = stale = 0; queue empty; pointers 0.
REQ-035 Outputs during and immediately after reset: imem_rmask 0 while rst high, imem_addr RESET_PC, deq_valid 0, occupancy 0.
REQ-036 Reset mid-operation discards all queued entries and forgets in-flight requests; first issue cycle is the first cycle with rst low.
REQ-037 Reset has priority over redirect, issue, response and dequeue.

Verification
REQ-038 Reset release, 1-cycle imem, deq_ready=1 -> addresses aaaaa000, aaaaa004, aaaaa008 issued consecutively; deq_pc matches with deq_inst = returned word.
REQ-039 deq_ready=0, DEPTH=4, MAX_OUTSTANDING=2 -> exactly 4 requests issued, occupancy reaches 4, imem_rmask stays 0 thereafter; one deq frees one issue.
REQ-040 2 requests in flight (aaaaa000, aaaaa004), redirect to 0x00001000 before responses -> both responses dropped, first dequeued deq_pc = 0x00001000.
REQ-041 Redirect in same cycle as a response and deq handshake -> response dropped, occupancy 0 next cycle, stale = outstanding-1.
REQ-042 redirect_pc = 0xfffffffc -> deq_pc sequence 0xfffffffc, 0x00000000.
REQ-043 Assert rst with 3 entries queued and 2 outstanding -> next cycle occupancy 0, deq_valid 0, imem_addr aaaaa000, late responses ignored.
